// File: rtl/dbg_jtag_dtm.sv
// RISC-V JTAG debug transport: 1149.1 TAP with IDCODE/DTMCS/DMI/BYPASS registers,
// turning DMI scans into valid/ready requests and collecting responses, all on TCK.
module dbg_jtag_dtm #(
    parameter int          ABITS      = 7,
    parameter logic [31:0] IDCODE_VAL = 32'h20000913,
    parameter int          IDLE_HINT  = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tms,
    input  logic             tdi,
    output logic             tdo,
    output logic             tdo_en,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_resp_valid,
    output logic             dmi_resp_ready,
    input  logic [31:0]      dmi_resp_data,
    input  logic [1:0]       dmi_resp_resp,
    output logic             dmi_hard_reset
);

    localparam int         DRW         = ABITS + 34;
    localparam logic [2:0] IDLE_FIELD  = 3'(IDLE_HINT);
    localparam logic [5:0] ABITS_FIELD = 6'(ABITS);

    typedef enum logic [3:0] {
        ST_TLR, ST_RTI, ST_SEL_DR, ST_CAP_DR, ST_SHIFT_DR, ST_EXIT1_DR, ST_PAUSE_DR, ST_EXIT2_DR,
        ST_UPD_DR, ST_SEL_IR, ST_CAP_IR, ST_SHIFT_IR, ST_EXIT1_IR, ST_PAUSE_IR, ST_EXIT2_IR, ST_UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {
        SEL_BYPASS, SEL_IDCODE, SEL_DTMCS, SEL_DMI
    } dr_sel_e;

    function automatic tap_state_e tap_next(input tap_state_e cur, input logic m);
        case (cur)
            ST_TLR:      tap_next = m ? ST_TLR      : ST_RTI;
            ST_RTI:      tap_next = m ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   tap_next = m ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   tap_next = m ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: tap_next = m ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: tap_next = m ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: tap_next = m ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: tap_next = m ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   tap_next = m ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   tap_next = m ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   tap_next = m ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: tap_next = m ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: tap_next = m ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: tap_next = m ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: tap_next = m ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   tap_next = m ? ST_SEL_DR   : ST_RTI;
            default:     tap_next = ST_TLR;
        endcase
    endfunction

    tap_state_e       state_r;
    logic [4:0]       ir_r;
    logic [4:0]       ir_shift_r;
    logic [DRW-1:0]   dr_r;
    logic             req_valid_r;
    logic [ABITS-1:0] req_addr_r;
    logic [31:0]      req_data_r;
    logic [1:0]       req_op_r;
    logic             resp_pending_r;
    logic [ABITS-1:0] last_addr_r;
    logic [31:0]      resp_data_r;
    logic [1:0]       sticky_r;
    logic             hard_reset_r;

    dr_sel_e          sel_s;
    logic             busy_s;
    logic [1:0]       dmi_status_s;
    logic [DRW-1:0]   dr_capture_s;
    logic [DRW-1:0]   dr_shift_s;

    // Instruction decode and the DMI busy/status view seen by capture and update.
    always_comb begin
        case (ir_r)
            5'h01:   sel_s = SEL_IDCODE;
            5'h10:   sel_s = SEL_DTMCS;
            5'h11:   sel_s = SEL_DMI;
            default: sel_s = SEL_BYPASS;
        endcase
        busy_s = req_valid_r | resp_pending_r;
        if (sticky_r != 2'd0) begin
            dmi_status_s = sticky_r;
        end else if (busy_s) begin
            dmi_status_s = 2'd3;
        end else begin
            dmi_status_s = 2'd0;
        end
    end

    // Capture values and the shift path; tdi enters at the MSB of the selected register.
    always_comb begin
        dr_shift_s = {1'b0, dr_r[DRW-1:1]};
        case (sel_s)
            SEL_IDCODE: begin
                dr_capture_s  = {{(DRW-32){1'b0}}, IDCODE_VAL[31:1], 1'b1};
                dr_shift_s[31] = tdi;
            end
            SEL_DTMCS: begin
                dr_capture_s  = {{(DRW-32){1'b0}}, 15'd0, IDLE_FIELD, sticky_r, ABITS_FIELD, 4'd1};
                dr_shift_s[31] = tdi;
            end
            SEL_DMI: begin
                dr_capture_s      = {last_addr_r, resp_data_r, dmi_status_s};
                dr_shift_s[DRW-1] = tdi;
            end
            default: begin
                dr_capture_s  = {DRW{1'b0}};
                dr_shift_s[0] = tdi;
            end
        endcase
    end

    // TAP controller state and instruction register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_TLR;
            ir_r       <= 5'h01;
            ir_shift_r <= 5'h00;
        end else begin
            state_r <= tap_next(state_r, tms);
            case (state_r)
                ST_TLR:      ir_r       <= 5'h01;
                ST_CAP_IR:   ir_shift_r <= 5'b00001;
                ST_SHIFT_IR: ir_shift_r <= {tdi, ir_shift_r[4:1]};
                ST_UPD_IR:   ir_r       <= ir_shift_r;
                default:     ir_r       <= ir_r;
            endcase
        end
    end

    // Shared data-register shift chain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dr_r <= {DRW{1'b0}};
        end else if (state_r == ST_CAP_DR) begin
            dr_r <= dr_capture_s;
        end else if (state_r == ST_SHIFT_DR) begin
            dr_r <= dr_shift_s;
        end else begin
            dr_r <= dr_r;
        end
    end

    // DMI handshake, response collection, sticky error and DTMCS control actions.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_valid_r    <= 1'b0;
            req_addr_r     <= {ABITS{1'b0}};
            req_data_r     <= 32'd0;
            req_op_r       <= 2'd0;
            resp_pending_r <= 1'b0;
            last_addr_r    <= {ABITS{1'b0}};
            resp_data_r    <= 32'd0;
            sticky_r       <= 2'd0;
            hard_reset_r   <= 1'b0;
        end else begin
            hard_reset_r <= 1'b0;
            if (req_valid_r && dmi_req_ready) begin
                req_valid_r    <= 1'b0;
                resp_pending_r <= 1'b1;
            end
            if (resp_pending_r && dmi_resp_valid) begin
                resp_pending_r <= 1'b0;
                resp_data_r    <= dmi_resp_data;
                if (dmi_resp_resp != 2'd0 && sticky_r == 2'd0) begin
                    sticky_r <= 2'd2;
                end
            end
            if (state_r == ST_CAP_DR && sel_s == SEL_DMI && sticky_r == 2'd0 && busy_s) begin
                sticky_r <= 2'd3;
            end
            if (state_r == ST_UPD_DR) begin
                case (sel_s)
                    SEL_DMI: begin
                        if (sticky_r != 2'd0) begin
                            sticky_r <= sticky_r;
                        end else if (busy_s) begin
                            sticky_r <= 2'd3;
                        end else if (dr_r[1:0] == 2'd1 || dr_r[1:0] == 2'd2) begin
                            req_valid_r <= 1'b1;
                            req_addr_r  <= dr_r[DRW-1:34];
                            req_data_r  <= dr_r[33:2];
                            req_op_r    <= dr_r[1:0];
                            last_addr_r <= dr_r[DRW-1:34];
                        end
                    end
                    SEL_DTMCS: begin
                        // Hard reset abandons any outstanding transaction outright.
                        if (dr_r[17]) begin
                            hard_reset_r   <= 1'b1;
                            req_valid_r    <= 1'b0;
                            resp_pending_r <= 1'b0;
                            sticky_r       <= 2'd0;
                        end else if (dr_r[16]) begin
                            sticky_r <= 2'd0;
                        end
                    end
                    default: hard_reset_r <= 1'b0;
                endcase
            end
        end
    end

    assign tdo            = (state_r == ST_SHIFT_IR) ? ir_shift_r[0] : dr_r[0];
    assign tdo_en         = (state_r == ST_SHIFT_IR) || (state_r == ST_SHIFT_DR);
    assign dmi_req_valid  = req_valid_r;
    assign dmi_req_addr   = req_addr_r;
    assign dmi_req_data   = req_data_r;
    assign dmi_req_op     = req_op_r;
    assign dmi_resp_ready = resp_pending_r;
    assign dmi_hard_reset = hard_reset_r;

endmodule

// File: tb/tb_dbg_jtag_dtm.sv
// Directed bench for dbg_jtag_dtm: TAP scans of IDCODE, DTMCS, BYPASS and DMI with a hand-driven DMI target.
module tb_dbg_jtag_dtm;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        tms = 1'b1;
    logic        tdi = 1'b0;
    logic        tdo;
    logic        tdo_en;
    logic        dmi_req_valid;
    logic        dmi_req_ready = 1'b0;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic [1:0]  dmi_req_op;
    logic        dmi_resp_valid = 1'b0;
    logic        dmi_resp_ready;
    logic [31:0] dmi_resp_data = 32'd0;
    logic [1:0]  dmi_resp_resp = 2'd0;
    logic        dmi_hard_reset;

    int          total = 0;
    int          bad = 0;
    int          en_cnt = 0;
    logic        tdo_smp;
    logic        en_smp;
    logic [63:0] dout;
    logic [4:0]  irout;

    localparam logic [63:0] IDCODE = 64'h20000913;

    dbg_jtag_dtm dut (
        .clock(clock), .reset_n(reset_n), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready), .dmi_req_addr(dmi_req_addr),
        .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op), .dmi_resp_valid(dmi_resp_valid),
        .dmi_resp_ready(dmi_resp_ready), .dmi_resp_data(dmi_resp_data), .dmi_resp_resp(dmi_resp_resp),
        .dmi_hard_reset(dmi_hard_reset)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        dmi_word = {23'd0, a, d, op};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One TCK cycle: drive after the falling edge, sample before the rising edge.
    task automatic step(input logic m, input logic d);
        @(negedge clock);
        tms = m;
        tdi = d;
        #1;
        tdo_smp = tdo;
        en_smp  = tdo_en;
        if (tdo_en) en_cnt++;
    endtask

    task automatic scan_ir(input logic [4:0] val, output logic [4:0] cap);
        cap = 5'd0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(i == 4, val[i]);
            cap[i] = tdo_smp;
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic scan_dr(input logic [63:0] din, input int n, output logic [63:0] res);
        res = 64'd0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i]);
            res[i] = tdo_smp;
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_outputs", {62'd0, tdo, tdo_en}, 64'd0);
        check("rst_dmi", {dmi_req_valid, dmi_resp_ready, dmi_hard_reset, dmi_req_op, dmi_req_addr, dmi_req_data}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b0, 1'b0);
        en_cnt = 0;
        scan_dr(64'd0, 32, dout);
        check("idcode_default", dout, IDCODE);
        check("idcode_tdo_en_cycles", 64'(en_cnt), 64'd32);

        // DTMCS capture and IR capture pattern
        scan_ir(5'h10, irout);
        check("ir_capture", {59'd0, irout}, 64'd1);
        scan_dr(64'd0, 32, dout);
        check("dtmcs_capture", dout, 64'h5071);

        // BYPASS: one-cycle delay with leading zero
        scan_ir(5'h1F, irout);
        scan_dr(64'hD, 4, dout);
        check("bypass_stream", dout, 64'hA);

        // DMI write, ready after three cycles
        scan_ir(5'h11, irout);
        scan_dr(dmi_word(7'h10, 32'h1, 2'd2), 41, dout);
        check("dmi_first_capture", dout, 64'd0);
        step(1'b0, 1'b0);
        check("wr_req", {dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op}, {1'b1, 7'h10, 32'h1, 2'd2});
        step(1'b0, 1'b0);
        check("wr_hold1", {63'd0, dmi_req_valid}, 64'd1);
        step(1'b0, 1'b0);
        check("wr_hold2", {63'd0, dmi_req_valid}, 64'd1);
        dmi_req_ready = 1'b1;
        step(1'b0, 1'b0);
        dmi_req_ready = 1'b0;
        check("wr_accepted", {62'd0, dmi_req_valid, dmi_resp_ready}, 64'd1);
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'h55;
        step(1'b0, 1'b0);
        dmi_resp_valid = 1'b0;
        check("wr_resp_done", {63'd0, dmi_resp_ready}, 64'd0);
        scan_dr(dmi_word(7'h0, 32'h0, 2'd0), 41, dout);
        check("wr_capture_ok", dout, dmi_word(7'h10, 32'h55, 2'd0));

        // Busy: second scan while the first is still outstanding
        scan_dr(dmi_word(7'h05, 32'h0, 2'd1), 41, dout);
        check("busy_first_capture", dout, dmi_word(7'h10, 32'h55, 2'd0));
        scan_dr(dmi_word(7'h06, 32'h0, 2'd1), 41, dout);
        check("busy_second_capture", dout, dmi_word(7'h05, 32'h55, 2'd3));
        step(1'b0, 1'b0);
        check("busy_not_reissued", {56'd0, dmi_req_valid, dmi_req_addr}, {56'd0, 1'b1, 7'h05});
        dmi_req_ready = 1'b1;
        step(1'b0, 1'b0);
        dmi_req_ready = 1'b0;
        check("busy_accepted", {62'd0, dmi_req_valid, dmi_resp_ready}, 64'd1);
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'h77;
        step(1'b0, 1'b0);
        dmi_resp_valid = 1'b0;
        scan_ir(5'h10, irout);
        scan_dr(64'h1_0000, 32, dout);
        check("dtmcs_sticky_busy", dout, 64'h5C71);
        scan_ir(5'h11, irout);
        scan_dr(dmi_word(7'h0, 32'h0, 2'd0), 41, dout);
        check("dmireset_cleared", dout, dmi_word(7'h05, 32'h77, 2'd0));

        // Failed read response
        scan_dr(dmi_word(7'h08, 32'h0, 2'd1), 41, dout);
        step(1'b0, 1'b0);
        check("rd_req", {dmi_req_valid, dmi_req_addr, dmi_req_op}, {54'd0, 1'b1, 7'h08, 2'd1});
        dmi_req_ready = 1'b1;
        step(1'b0, 1'b0);
        dmi_req_ready = 1'b0;
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'hDEADBEEF;
        dmi_resp_resp  = 2'd2;
        step(1'b0, 1'b0);
        dmi_resp_valid = 1'b0;
        dmi_resp_resp  = 2'd0;
        scan_dr(dmi_word(7'h0, 32'h0, 2'd0), 41, dout);
        check("rd_fail_capture", dout, dmi_word(7'h08, 32'hDEADBEEF, 2'd2));
        scan_ir(5'h10, irout);
        scan_dr(64'h1_0000, 32, dout);
        check("dtmcs_sticky_fail", dout, 64'h5871);

        // Hard reset with a request pending
        scan_ir(5'h11, irout);
        scan_dr(dmi_word(7'h09, 32'h0, 2'd1), 41, dout);
        check("hr_pre_capture", dout, dmi_word(7'h08, 32'hDEADBEEF, 2'd0));
        step(1'b0, 1'b0);
        check("hr_pending", {63'd0, dmi_req_valid}, 64'd1);
        scan_ir(5'h10, irout);
        scan_dr(64'h2_0000, 32, dout);
        step(1'b0, 1'b0);
        check("hr_pulse", {62'd0, dmi_hard_reset, dmi_req_valid}, 64'd2);
        step(1'b0, 1'b0);
        check("hr_pulse_end", {61'd0, dmi_hard_reset, dmi_req_valid, dmi_resp_ready}, 64'd0);

        // Five tms=1 cycles with a request in flight
        scan_ir(5'h11, irout);
        scan_dr(dmi_word(7'h0A, 32'h0, 2'd1), 41, dout);
        check("tlr_pre_capture", dout, dmi_word(7'h09, 32'hDEADBEEF, 2'd0));
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        scan_dr(64'd0, 32, dout);
        check("tlr_ir_idcode", dout, IDCODE);
        check("tlr_valid_held", {56'd0, dmi_req_valid, dmi_req_addr}, {56'd0, 1'b1, 7'h0A});
        dmi_req_ready = 1'b1;
        step(1'b0, 1'b0);
        dmi_req_ready = 1'b0;
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'h99;
        step(1'b0, 1'b0);
        dmi_resp_valid = 1'b0;

        // Asynchronous reset in the middle of Shift-DR
        scan_ir(5'h11, irout);
        scan_dr(dmi_word(7'h0B, 32'h0, 2'd1), 41, dout);
        check("ar_pre_capture", dout, dmi_word(7'h0A, 32'h99, 2'd0));
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("ar_in_shift", {62'd0, en_smp, dmi_req_valid}, 64'd3);
        reset_n = 1'b0;
        #1;
        check("ar_outputs", {59'd0, tdo, tdo_en, dmi_req_valid, dmi_resp_ready, dmi_hard_reset}, 64'd0);
        tms = 1'b1;
        #2;
        reset_n = 1'b1;
        step(1'b0, 1'b0);
        scan_dr(64'd0, 32, dout);
        check("ar_tlr_idcode", dout, IDCODE);
        check("ar_no_request", {63'd0, dmi_req_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbg_jtag_dtm.md
Name: dbg_jtag_dtm

Overview:
- JTAG Debug Transport Module per RISC-V Debug Spec 0.13. It is the stage directly upstream of the debug module's DMI crossing.
- Runs entirely on TCK. Contains the IEEE 1149.1 TAP controller and the IR, IDCODE, DTMCS, DMI and BYPASS data registers.
- Converts DMI scans into valid/ready DMI requests and collects the DMI responses.

Parameters:
- ABITS, 7, DMI address width.
- IDCODE_VAL, 32'h20000913, IDCODE register value; bit 0 is forced to 1.
- IDLE_HINT, 5, value reported in the DTMCS idle field (3 bits).

Ports:
- clock  in  1  JTAG TCK; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tms  in  1  JTAG TMS.
- tdi  in  1  JTAG TDI.
- tdo  out  1  combinational; bit 0 of the selected shift register. Retiming to the falling edge is done outside this block.
- tdo_en  out  1  high in Shift-IR or Shift-DR.
- dmi_req_valid  out  1  DMI request valid.
- dmi_req_ready  in  1  DMI request ready.
- dmi_req_addr  out  ABITS  DMI request address.
- dmi_req_data  out  32  DMI request write data.
- dmi_req_op  out  2  1=read, 2=write.
- dmi_resp_valid  in  1  DMI response valid.
- dmi_resp_ready  out  1  DMI response ready.
- dmi_resp_data  in  32  DMI response read data.
- dmi_resp_resp  in  2  0=ok, nonzero=failed.
- dmi_hard_reset  out  1  one-cycle pulse on a DTMCS dmihardreset write.

Behaviour:
- Reset (async, reset_n low):
  - TAP goes to Test-Logic-Reset; IR=5'h01.
  - All outputs are 0; sticky error=0; no request or response pending.
- TAP FSM: the standard 16-state 1149.1 graph driven by tms. Five consecutive tms=1 cycles reach Test-Logic-Reset from any state.
- Test-Logic-Reset: IR=5'h01. A pending DMI transaction is NOT aborted.
- IR (5 bits):
  - Capture-IR loads 5'b00001. Shift-IR shifts LSB-first, tdi into the MSB.
  - IR is latched at Update-IR.
  - Decode: 0x01 IDCODE, 0x10 DTMCS, 0x11 DMI; all other values select BYPASS.
- IDCODE (32 bits): loaded at Capture-DR.
- BYPASS (1 bit): Capture-DR loads 0.
- DTMCS (32 bits):
  - Capture-DR loads {15'b0, idle[14:12]=IDLE_HINT, dmistat[11:10]=sticky, abits[9:4]=ABITS, version[3:0]=1}.
  - Update-DR, bit16=1 (dmireset): clears sticky.
  - Update-DR, bit17=1 (dmihardreset): pulses dmi_hard_reset for one cycle, drops dmi_req_valid next cycle, clears pending/busy and clears sticky.
- DMI DR (ABITS+34 bits, {addr, data[33:2], op[1:0]}), Capture-DR:
  - Loads {last addr, last response data, status}.
  - status = sticky if nonzero; else 3 if busy, which also sets sticky=3.
  - busy = request outstanding (valid not yet accepted) or response not yet received.
- DMI DR, Update-DR:
  - If sticky≠0: ignored.
  - Else if busy: ignored, sticky=3.
  - Else op=1 or 2: the next cycle asserts dmi_req_valid with addr/data/op; these hold stable until the valid&ready cycle.
  - op=0 or 3: no-op.
- Response:
  - dmi_resp_ready=1 from request acceptance until the dmi_resp_valid cycle, inclusive.
  - That cycle latches data.
  - If resp≠0: sticky=2, unless sticky is already nonzero.
- Simultaneity:
  - Request acceptance in the same cycle as an Update-DR: the update sees busy.
  - Response in the same cycle as Capture-DR: capture sees busy (status 3).
- Sticky encoding: 0 ok, 2 failed, 3 busy. The first nonzero value wins until cleared.

Test Plan:
- Reset, go to Shift-DR without an IR scan, shift 32 bits -> tdo stream = 0x20000913 LSB-first; tdo_en high only during the 32 Shift-DR cycles.
- IR=0x10, Capture/shift DTMCS -> 0x00005071. IR=0x1F, tdi pattern 1011 -> tdo 0101… (one-cycle delay, leading 0).
- IR=0x11, scan addr=0x10, data=0x00000001, op=2, dmi_req_ready=1 after 3 cycles -> valid holds exactly until the handshake; resp ok; next capture op field = 0.
- Hold dmi_req_ready=0, issue two DMI scans -> second capture op=3, second request not issued. Then DTMCS write bit16 -> next DMI capture op=0.
- Read with dmi_resp_resp=2, data=0xDEADBEEF -> next capture op=2, data=0xDEADBEEF.
- DTMCS bit17 write while a request is pending -> dmi_hard_reset one-cycle pulse, dmi_req_valid low next cycle.
- reset_n asserted mid-Shift-DR -> all outputs 0 immediately, state Test-Logic-Reset.
- Five tms=1 cycles mid-transaction -> IR=0x01, valid still held.
